// File: rtl/multibit_fifo_word_packer.sv
// multibit_fifo_word_packer: packs IN_WIDTH beats LSB-lane first into IN_WIDTH*RATIO words for the multibit FIFO synchronizer.
// Define MULTIBIT_FIFO_WORD_PACKER_TIMEOUT_EN to auto-flush partial words after TIMEOUT_CYCLES idle cycles.
module multibit_fifo_word_packer #(
   parameter int IN_WIDTH       = 8,
   parameter int RATIO          = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         s_valid,
   input  logic [IN_WIDTH-1:0]          s_data,
   input  logic                         s_last,
   output logic                         s_ready,
   output logic                         m_valid,
   output logic [IN_WIDTH*RATIO-1:0]    m_data,
   output logic [$clog2(RATIO+1)-1:0]   m_count,
   output logic                         m_last,
   input  logic                         m_ready
);
   localparam int W  = IN_WIDTH * RATIO;
   localparam int CW = $clog2(RATIO + 1);
   localparam int LW = $clog2(RATIO);
   logic [LW-1:0] cnt;
   logic [W-1:0]  acc, merged, out_data;
   logic [CW-1:0] out_count;
   logic          out_last, out_valid, accept, complete, flush;
   assign s_ready  = !out_valid | m_ready;
   assign accept   = s_valid & s_ready;
   assign complete = accept & (s_last | cnt == LW'(RATIO - 1));
   assign m_valid  = out_valid;
   assign m_data   = out_data;
   assign m_count  = out_count;
   assign m_last   = out_last;
   // new beat lands in lane cnt; lanes above it are forced to zero
   for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign merged[g*IN_WIDTH +: IN_WIDTH] = cnt == LW'(g) ? s_data :
                                              cnt >  LW'(g) ? acc[g*IN_WIDTH +: IN_WIDTH] : '0;
   end
`ifdef MULTIBIT_FIFO_WORD_PACKER_TIMEOUT_EN
   logic [15:0] idle_cnt;
   logic        idle_hit;
   assign idle_hit = idle_cnt == 16'(TIMEOUT_CYCLES - 1);
   assign flush    = idle_hit & cnt != '0 & s_ready & !accept;
   // saturates at the threshold so a blocked flush fires as soon as the output frees up
   always_ff @(posedge aclk)
      if (areset || accept || flush || cnt == '0) idle_cnt <= '0;
      else if (!idle_hit) idle_cnt <= idle_cnt + 16'd1;
`else
   assign flush = 1'b0;
`endif
   always_ff @(posedge aclk) begin
      if (areset) begin
         cnt       <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (m_ready) out_valid <= 1'b0;
         if (complete || flush) begin
            out_data  <= complete ? merged : acc;
            out_count <= complete ? CW'(cnt) + CW'(1) : CW'(cnt);
            out_last  <= complete & s_last;
            out_valid <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
         end else if (accept) begin
            cnt <= cnt + LW'(1);
            acc <= merged;
         end
      end
   end
endmodule

// File: tb/tb_multibit_fifo_word_packer.sv
// tb_multibit_fifo_word_packer: scoreboard bench for the word packer (RATIO=4, IN_WIDTH=8).
module tb_multibit_fifo_word_packer;
   localparam int T = 16;
   logic        aclk, areset, s_valid, s_last, s_ready, m_valid, m_last, m_ready;
   logic [7:0]  s_data;
   logic [31:0] m_data;
   logic [2:0]  m_count;
   int checks = 0, failures = 0;
   typedef struct {logic [31:0] d; int c; bit l;} word_t;
   word_t       q[$];
   logic [31:0] popped[$];
   logic [31:0] macc;
   int          mcnt, midle;

   multibit_fifo_word_packer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT_CYCLES(T)) dut (
      .aclk(aclk), .areset(areset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_count(m_count),
      .m_last(m_last), .m_ready(m_ready)
   );

   initial begin
      aclk = 0;
      forever #5 aclk = ~aclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model of the output register, lane counter and idle counter
   always @(negedge aclk) begin
      bit rdy, acc_en, fl;
      if (areset) begin
         q.delete();
         macc = 0; mcnt = 0; midle = 0;
      end else begin
         rdy = q.size() == 0 || m_ready;
         check("s_ready", s_ready, rdy);
         check("m_valid", m_valid, q.size() != 0);
         if (q.size() != 0) begin
            check("m_data", m_data, q[0].d);
            check("m_count", m_count, q[0].c);
            check("m_last", m_last, q[0].l);
            if (m_ready) begin
               popped.push_back(q[0].d);
               void'(q.pop_front());
            end
         end
         acc_en = s_valid && rdy;
         fl = 0;
`ifdef MULTIBIT_FIFO_WORD_PACKER_TIMEOUT_EN
         fl = !acc_en && rdy && mcnt > 0 && midle == T - 1;
         if (acc_en || fl || mcnt == 0) midle = 0;
         else if (midle != T - 1) midle++;
`endif
         if (acc_en) begin
            macc[mcnt*8 +: 8] = s_data;
            if (mcnt == 3 || s_last) begin
               q.push_back('{macc, mcnt + 1, s_last});
               macc = 0; mcnt = 0;
            end else mcnt++;
         end else if (fl) begin
            q.push_back('{macc, mcnt, 1'b0});
            macc = 0; mcnt = 0;
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit l);
      int n = 0;
      s_valid = 1; s_data = d; s_last = l;
      @(negedge aclk);
      while (!s_ready && n < 100) begin
         n++;
         @(negedge aclk);
      end
      if (n >= 100) check("send_timeout", 0, 1);
      @(posedge aclk); #1;
      s_valid = 0; s_last = 0;
   endtask

   task automatic do_reset(input string tag);
      areset = 1;
      @(posedge aclk); #1;
      areset = 0;
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_m_count"}, m_count, 0);
      check({tag, "_m_last"}, m_last, 0);
      check({tag, "_s_ready"}, s_ready, 1);
      check({tag, "_cnt"}, dut.cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      s_valid = 0; s_data = 0; s_last = 0; m_ready = 1; areset = 1;
      repeat (2) @(posedge aclk);
      #1;
      do_reset("rst");
      // fill
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      check("fill_valid", m_valid, 1);
      check("fill_data", m_data, 32'h44332211);
      check("fill_count", m_count, 4);
      check("fill_last", m_last, 0);
      // partial flush
      send(8'hAA, 0); send(8'hBB, 1);
      check("part_data", m_data, 32'h0000BBAA);
      check("part_count", m_count, 2);
      check("part_last", m_last, 1);
      check("part_cnt", dut.cnt, 0);
      // last on first lane and last on final lane
      send(8'h5C, 1);
      check("one_data", m_data, 32'h0000005C);
      check("one_count", m_count, 1);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
      check("full_last_count", m_count, 4);
      check("full_last_last", m_last, 1);
      // backpressure
      @(posedge aclk); #1;
      m_ready = 0;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk); #1;
         check("bp_hold", m_data, 32'h04030201);
         check("bp_s_ready", s_ready, 0);
      end
      m_ready = 1; #1;
      check("bp_release_s_ready", s_ready, 1);
      @(posedge aclk); #1;
      check("bp_drained", m_valid, 0);
      // streaming
      popped.delete();
      for (int i = 0; i < 64; i++) send(8'(i), 0);
      repeat (2) @(posedge aclk);
      #1;
      check("stream_words", popped.size(), 16);
      if (popped.size() == 16) begin
         check("stream_first", popped[0], 32'h03020100);
         check("stream_final", popped[15], 32'h3F3E3D3C);
      end
      // reset with pending word, then mid-fill
      m_ready = 0;
      send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 0);
      do_reset("rst_pend");
      m_ready = 1;
      send(8'hE1, 0); send(8'hE2, 0);
      do_reset("rst_fill");
      send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
      check("post_rst_data", m_data, 32'hC4C3C2C1);
      send(8'hF1, 1);
      check("post_rst_part", m_data, 32'h000000F1);
      // idle partial word
      @(posedge aclk); #1;
      send(8'h5A, 0);
`ifdef MULTIBIT_FIFO_WORD_PACKER_TIMEOUT_EN
      repeat (15) @(posedge aclk);
      #1;
      check("to_early", m_valid, 0);
      @(posedge aclk); #1;
      check("to_valid", m_valid, 1);
      check("to_data", m_data, 32'h0000005A);
      check("to_count", m_count, 1);
      check("to_last", m_last, 0);
`else
      repeat (40) @(posedge aclk);
      #1;
      check("idle_no_out", m_valid, 0);
      check("idle_cnt", dut.cnt, 1);
      send(8'h00, 1);
      check("idle_flush_data", m_data, 32'h0000005A);
      check("idle_flush_count", m_count, 2);
`endif
      repeat (3) @(posedge aclk);
      #1;
      check("sb_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multibit_fifo_word_packer.md
Name: multibit_fifo_word_packer

Overview:
- aclk-domain upstream stage of the 1-deep multibit FIFO synchronizer.
- Packs narrow IN_WIDTH beats, LSB-lane first, into IN_WIDTH*RATIO words.
- Output side is a valid/ready producer: m_valid/m_data drive the synchronizer's avalid/adata, and m_ready is driven by its aready.
- Amortizes the slow CDC handshake over RATIO beats; supports early flush of partial words via s_last.

Parameters:
- IN_WIDTH, 8, width of one input beat.
- RATIO, 4, beats per output word; legal range 2..16.
- TIMEOUT_CYCLES, 16, idle cycles before auto-flush; used only with the optional feature; legal range 1..65535.

Ports:
- aclk  input  1  clock.
- areset  input  1  synchronous active-high reset.
- s_valid  input  1  input beat valid.
- s_data  input  IN_WIDTH  input beat.
- s_last  input  1  flush after this beat.
- s_ready  output  1  input beat accepted when s_valid&s_ready.
- m_valid  output  1  packed word valid (to avalid).
- m_data  output  IN_WIDTH*RATIO  packed word (to adata).
- m_count  output  $clog2(RATIO+1)  number of valid lanes, 1..RATIO.
- m_last  output  1  word closed by s_last.
- m_ready  input  1  downstream ready (from aready).

Behaviour:
- Reset and clock: areset and aclk only; no other clock or reset.
- State:
  - accumulator acc[IN_WIDTH*RATIO], lane counter cnt (0..RATIO-1), output register (out_data, out_count, out_last, out_valid).
  - Optional feature adds idle counter idle_cnt.
- Reset (areset high at aclk edge):
  - m_valid=0, m_data=0, m_count=0, m_last=0, cnt=0, acc=0, idle_cnt=0.
  - Inputs ignored during reset.
  - First cycle after reset: s_ready=1.
  - Reset mid-operation discards any partial and pending word.
- s_ready = !m_valid | m_ready. Combinational from registers and m_ready only; never depends on s_valid, s_data or s_last.
- Accept (s_valid&s_ready):
  - s_data is written to lane cnt, bits [cnt*IN_WIDTH +: IN_WIDTH].
- Completion: an accepted beat with cnt==RATIO-1 or s_last=1.
  - Output register loads {acc with the new lane merged, count=cnt+1, last=s_last}.
  - Lanes >= cnt+1 are forced to zero.
  - cnt and acc clear to 0 in the same edge.
  - m_valid=1 from the next cycle. Latency: final beat accepted in cycle N → m_valid in N+1.
- Non-completing accept: cnt increments; output register is untouched.
- Output handshake:
  - m_valid&m_ready drains the word.
  - If a completion occurs in the same cycle, the new word replaces it, so m_valid stays 1 (back-to-back words, no bubble).
  - Otherwise m_valid falls next cycle.
- Stability: while m_valid&!m_ready, m_data, m_count and m_last are held constant, and s_ready=0, so no input is accepted.
- Full throughput: with m_ready tied high, one beat is accepted every cycle indefinitely.
- s_last when cnt==RATIO-1: a single full word with m_count=RATIO and m_last=1.
- s_last on the first lane: m_count=1, upper lanes zero.
- Idle with cnt>0: the partial word is held indefinitely (unless the optional feature is enabled).
- No state machine beyond cnt and out_valid. Implicit states:
  - EMPTY (cnt=0, !out_valid)
  - FILLING (cnt>0)
  - HOLD (out_valid)
  - FILLING and HOLD may coexist only transiently within a cycle; new beats are blocked in HOLD unless m_ready.

Optional Feature:
- Macro: MULTIBIT_FIFO_WORD_PACKER_TIMEOUT_EN.
- Defined:
  - idle_cnt counts cycles with cnt>0 and no accepted beat.
  - idle_cnt resets to 0 on any accept, on any flush, or when cnt==0.
  - When idle_cnt==TIMEOUT_CYCLES-1 and (!m_valid|m_ready), the partial word is flushed next edge: m_count=cnt, m_last=0, cnt cleared.
  - If the output is blocked, the flush waits, with idle_cnt saturating.
  - A flush and an accept never coincide: an accept takes priority and resets idle_cnt.
- Undefined: no idle_cnt logic; partial words leave only via s_last or fill.

Test Plan:
- Fill (RATIO=4, IN_WIDTH=8, m_ready=1): beats 0x11,0x22,0x33,0x44 in cycles 0-3 → cycle 4: m_valid=1, m_data=0x44332211, m_count=4, m_last=0.
- Partial flush: beats 0xAA, then 0xBB with s_last=1 → m_data=0x0000BBAA, m_count=2, m_last=1; cnt returns to 0.
- Backpressure: m_ready=0 while a word is pending → s_ready=0; m_data held constant for 10 cycles; raise m_ready → drain, s_ready=1 the same cycle.
- Streaming: 64 consecutive beats 0x00..0x3F, m_ready=1 → 16 words, no gaps, first 0x03020100, last 0x3F3E3D3C.
- Reset: areset mid-fill after 2 beats and with a pending word → m_valid=0, outputs zero; next 4 beats produce a fresh full word with no stale lanes.
- Timeout (macro defined, TIMEOUT_CYCLES=16): one beat 0x5A, then idle → word m_data=0x0000005A, m_count=1, m_last=0 appears 16 cycles after the beat; without the macro, no output.
